// File: rtl/tmds_word_align_ctrl_pkg.sv
// Shared definitions for the TMDS word-alignment controller.
//   COM00..COM11        : the four 10-bit HDMI/DVI control tokens (raw, pre-decode)
//   TMDS_SLIP_POSITIONS : number of distinct bit-slip positions in a 10-bit word
//   AlignState_t        : alignment FSM states
//   is_ctrl_token()     : true when a raw word is one of the four control tokens
package tmds_word_align_ctrl_pkg;

  localparam logic [9:0] COM00 = 10'b1101010100;
  localparam logic [9:0] COM01 = 10'b0010101011;
  localparam logic [9:0] COM10 = 10'b0101010100;
  localparam logic [9:0] COM11 = 10'b1010101011;

  localparam int TMDS_SLIP_POSITIONS = 10;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } AlignState_t;

  function automatic logic is_ctrl_token(input logic [9:0] word);
    return (word == COM00) || (word == COM01) || (word == COM10) || (word == COM11);
  endfunction

endpackage

// File: rtl/tmds_word_align_ctrl_run_counter.sv
// Control-token detector plus saturating consecutive-run counter.
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   data_i   in   raw 10-bit TMDS word
//   clr      in   hold the run counter at zero
//   is_ctrl  out  combinational: data_i is a control token
//   run_cnt  out  consecutive tokens seen, saturating at LOCK_COUNT-1
module tmds_ctrl_run_counter
  import tmds_word_align_ctrl_pkg::*;
#(
  parameter int LOCK_COUNT = 64,
  parameter int RUN_W      = $clog2(LOCK_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       data_i,
  input  logic             clr,
  output logic             is_ctrl,
  output logic [RUN_W-1:0] run_cnt
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT - 1);

  logic [RUN_W-1:0] run_cnt_q;
  logic [RUN_W-1:0] run_cnt_d;

  assign is_ctrl = is_ctrl_token(data_i);
  assign run_cnt = run_cnt_q;

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (clr || !is_ctrl) begin
      run_cnt_d = '0;
    end else if (run_cnt_q != RUN_MAX) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

endmodule

// File: rtl/tmds_word_align_ctrl.sv
// Per-channel TMDS word-alignment controller.
// Hunts for a long run of consecutive control tokens (blanking interval); if none
// shows up within SEARCH_TIMEOUT cycles it pulses bitslip, waits SETTLE_CYCLES for
// the deserializer to realign, and searches again. Once aligned it holds lock until
// LOSS_TIMEOUT cycles pass without a single control token.
//   clk        in   pixel clock
//   rst        in   synchronous active-high reset
//   dataTx     in   raw 10-bit word from the deserializer
//   bitslip    out  one-cycle slip request
//   locked     out  word alignment established
//   slipCount  out  current slip position 0..9
//   alignFail  out  sticky: full sweep of all positions completed without lock
//
// state  | meaning
// SEARCH | counting consecutive tokens, timing out towards a slip
// SLIP   | single cycle with bitslip asserted
// SETTLE | input ignored while the deserializer realigns
// LOCKED | aligned; watching for prolonged absence of tokens
module tmds_word_align_ctrl
  import tmds_word_align_ctrl_pkg::*;
#(
  parameter int LOCK_COUNT     = 64,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SETTLE_CYCLES  = 8,
  parameter int LOSS_TIMEOUT   = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] dataTx,
  output logic       bitslip,
  output logic       locked,
  output logic [3:0] slipCount,
  output logic       alignFail
);

  localparam int RUN_W    = $clog2(LOCK_COUNT);
  localparam int TIMER_W  = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOSS_W   = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

  localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(LOCK_COUNT - 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(SEARCH_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_TIMEOUT - 1);
  localparam logic [3:0]          SLIP_LAST   = 4'(TMDS_SLIP_POSITIONS - 1);

  AlignState_t         state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic                bitslip_q, bitslip_d;
  logic                locked_q, locked_d;
  logic [3:0]          slip_count_q, slip_count_d;
  logic                align_fail_q, align_fail_d;

  logic             is_ctrl;
  logic [RUN_W-1:0] run_cnt;

  // The run counter only accumulates while searching, so every entry into
  // SEARCH starts from an empty run.
  tmds_ctrl_run_counter #(
    .LOCK_COUNT (LOCK_COUNT),
    .RUN_W      (RUN_W)
  ) u_run_counter (
    .clk     (clk),
    .rst     (rst),
    .data_i  (dataTx),
    .clr     (state_q != SEARCH),
    .is_ctrl (is_ctrl),
    .run_cnt (run_cnt)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    settle_cnt_d = settle_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    bitslip_d    = 1'b0;
    locked_d     = locked_q;
    slip_count_d = slip_count_q;
    align_fail_d = align_fail_q;

    case (state_q)
      SEARCH: begin
        // Lock takes priority over a simultaneous timeout.
        if (is_ctrl && run_cnt == RUN_LAST) begin
          state_d      = LOCKED;
          locked_d     = 1'b1;
          align_fail_d = 1'b0;
          loss_cnt_d   = '0;
          timer_d      = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = SLIP;
          bitslip_d = 1'b1;
          timer_d   = '0;
          if (slip_count_q == SLIP_LAST) begin
            slip_count_d = '0;
            align_fail_d = 1'b1;
          end else begin
            slip_count_d = slip_count_q + 4'd1;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      SLIP: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
      end

      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = SEARCH;
          timer_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end

      LOCKED: begin
        // A token on the final cycle still rescues the lock.
        if (is_ctrl) begin
          loss_cnt_d = '0;
        end else if (loss_cnt_q == LOSS_LAST) begin
          state_d    = SEARCH;
          locked_d   = 1'b0;
          loss_cnt_d = '0;
          timer_d    = '0;
        end else begin
          loss_cnt_d = loss_cnt_q + LOSS_W'(1);
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEARCH;
      timer_q      <= '0;
      settle_cnt_q <= '0;
      loss_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
      slip_count_q <= '0;
      align_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      settle_cnt_q <= settle_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      bitslip_q    <= bitslip_d;
      locked_q     <= locked_d;
      slip_count_q <= slip_count_d;
      align_fail_q <= align_fail_d;
    end
  end

  assign bitslip   = bitslip_q;
  assign locked    = locked_q;
  assign slipCount = slip_count_q;
  assign alignFail = align_fail_q;

endmodule

// File: tb/tb_tmds_word_align_ctrl.sv
module tb_tmds_word_align_ctrl;

  localparam int LOCK_N    = 8;
  localparam int TIMEOUT_N = 64;
  localparam int SETTLE_N  = 4;
  localparam int LOSS_N    = 32;

  localparam logic [9:0] T_COM00 = 10'h354;
  localparam logic [9:0] T_COM01 = 10'h0AB;
  localparam logic [9:0] T_COM10 = 10'h154;
  localparam logic [9:0] T_COM11 = 10'h2AB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] dataTx = '0;
  logic       bitslip;
  logic       locked;
  logic [3:0] slipCount;
  logic       alignFail;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] toks [4] = '{T_COM00, T_COM01, T_COM10, T_COM11};

  // Reference model: mode 0 = hunting, 1 = blind after a slip, 2 = aligned.
  int m_mode, m_age, m_run, m_blind, m_quiet, m_pos;
  bit m_locked, m_fail, m_slip;
  bit prev_bs;

  tmds_word_align_ctrl #(
    .LOCK_COUNT     (LOCK_N),
    .SEARCH_TIMEOUT (TIMEOUT_N),
    .SETTLE_CYCLES  (SETTLE_N),
    .LOSS_TIMEOUT   (LOSS_N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dataTx    (dataTx),
    .bitslip   (bitslip),
    .locked    (locked),
    .slipCount (slipCount),
    .alignFail (alignFail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_tok(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == toks[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] rnd_data();
    logic [9:0] w;
    do w = 10'($urandom); while (is_tok(w));
    return w;
  endfunction

  function automatic logic [9:0] rnd_tok();
    return toks[$urandom_range(0, 3)];
  endfunction

  task automatic model_step(input logic r, input logic [9:0] d);
    bit tok;
    tok    = is_tok(d);
    m_slip = 1'b0;
    if (r) begin
      m_mode = 0; m_age = 0; m_run = 0; m_blind = 0; m_quiet = 0;
      m_pos = 0; m_locked = 1'b0; m_fail = 1'b0;
    end else if (m_mode == 0) begin
      if (tok && m_run + 1 >= LOCK_N) begin
        m_mode = 2; m_locked = 1'b1; m_fail = 1'b0; m_quiet = 0;
      end else if (m_age + 1 >= TIMEOUT_N) begin
        m_slip  = 1'b1;
        m_pos   = (m_pos + 1) % 10;
        if (m_pos == 0) m_fail = 1'b1;
        m_mode  = 1;
        m_blind = SETTLE_N + 1;
      end else begin
        m_age++;
        m_run = tok ? m_run + 1 : 0;
      end
    end else if (m_mode == 1) begin
      m_blind--;
      if (m_blind == 0) begin
        m_mode = 0; m_age = 0; m_run = 0;
      end
    end else begin
      if (tok) m_quiet = 0;
      else if (m_quiet + 1 >= LOSS_N) begin
        m_mode = 0; m_locked = 1'b0; m_age = 0; m_run = 0;
      end else m_quiet++;
    end
  endtask

  task automatic tick(input logic r, input logic [9:0] d);
    rst    = r;
    dataTx = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    chk("bitslip", int'(bitslip), int'(m_slip));
    chk("locked", int'(locked), int'(m_locked));
    chk("slipCount", int'(slipCount), m_pos);
    chk("alignFail", int'(alignFail), int'(m_fail));
    if (!r) chk("bitslip_back_to_back", int'(prev_bs && bitslip), 0);
    prev_bs = bitslip;
  endtask

  initial begin
    int slips;
    int pos;
    int extra;
    bit found;

    // Reset state
    tick(1'b1, '0);
    tick(1'b1, '0);
    chk("rst_bitslip", int'(bitslip), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_slipCount", int'(slipCount), 0);
    chk("rst_alignFail", int'(alignFail), 0);

    // 1: eight COM00 words lock on the eighth
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, T_COM00);
      if (i == 6) chk("t1_no_lock_at_7", int'(locked), 0);
    end
    chk("t1_lock_at_8", int'(locked), 1);
    chk("t1_slipCount", int'(slipCount), 0);

    // 2: broken run does not lock; fresh run of 8 does
    tick(1'b1, '0);
    for (int i = 0; i < 7; i++) tick(1'b0, T_COM10);
    tick(1'b0, 10'h2AA);
    chk("t2_no_lock_after_break", int'(locked), 0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, T_COM01);
      if (i == 6) chk("t2_no_lock_at_7", int'(locked), 0);
    end
    chk("t2_lock_at_8", int'(locked), 1);

    // 3: data only -> slip at 64 then every 69 cycles; sweep sets alignFail
    tick(1'b1, '0);
    slips = 0;
    for (int c = 1; c <= 700; c++) begin
      tick(1'b0, rnd_data());
      if (bitslip) begin
        chk("t3_pulse_time", c, TIMEOUT_N + (TIMEOUT_N + SETTLE_N + 1) * slips);
        slips++;
        chk("t3_slip_pos", int'(slipCount), slips % 10);
        if (slips == 9) chk("t3_no_fail_after_9", int'(alignFail), 0);
        if (slips == 10) chk("t3_fail_after_10", int'(alignFail), 1);
      end
    end
    chk("t3_pulse_count", slips, 10);
    chk("t3_fail_sticky", int'(alignFail), 1);

    // 6a: reset during the SLIP cycle
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      tick(1'b0, rnd_data());
      if (bitslip) found = 1'b1;
    end
    chk("t6_slip_seen", int'(found), 1);
    tick(1'b1, rnd_data());
    chk("t6a_bitslip", int'(bitslip), 0);
    chk("t6a_locked", int'(locked), 0);
    chk("t6a_slipCount", int'(slipCount), 0);
    chk("t6a_alignFail", int'(alignFail), 0);

    // 4: deserializer aligned at slip position 3
    pos = 0; slips = 0; found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      tick(1'b0, (pos == 3) ? rnd_tok() : rnd_data());
      if (bitslip) begin pos = (pos + 1) % 10; slips++; end
      if (locked) found = 1'b1;
    end
    chk("t4_locked", int'(locked), 1);
    chk("t4_slipCount", int'(slipCount), 3);
    chk("t4_alignFail", int'(alignFail), 0);
    chk("t4_slips", slips, 3);
    extra = 0;
    for (int c = 0; c < 300; c++) begin
      tick(1'b0, rnd_tok());
      if (bitslip) extra++;
    end
    chk("t4_no_more_slips", extra, 0);

    // 5: token on the last allowed cycle keeps lock; 32 data words drop it
    for (int i = 0; i < LOSS_N - 1; i++) tick(1'b0, rnd_data());
    tick(1'b0, T_COM11);
    chk("t5_kept_by_token", int'(locked), 1);
    for (int i = 0; i < LOSS_N; i++) begin
      tick(1'b0, rnd_data());
      if (i == LOSS_N - 2) chk("t5_locked_at_31", int'(locked), 1);
    end
    chk("t5_lost_at_32", int'(locked), 0);
    chk("t5_slipCount_kept", int'(slipCount), 3);
    for (int i = 0; i < LOCK_N; i++) tick(1'b0, rnd_tok());
    chk("t5_relock_no_slip", int'(locked), 1);
    chk("t5_relock_pos", int'(slipCount), 3);

    // 6b: reset while LOCKED
    tick(1'b1, T_COM00);
    chk("t6b_bitslip", int'(bitslip), 0);
    chk("t6b_locked", int'(locked), 0);
    chk("t6b_slipCount", int'(slipCount), 0);
    chk("t6b_alignFail", int'(alignFail), 0);

    // Lock and timeout on the same edge: lock wins
    for (int i = 0; i < TIMEOUT_N - LOCK_N; i++) tick(1'b0, rnd_data());
    for (int i = 0; i < LOCK_N; i++) tick(1'b0, rnd_tok());
    chk("t7_lock_wins", int'(locked), 1);
    chk("t7_no_slip", int'(slipCount), 0);

    // Random bursts of tokens and data, model-checked every cycle
    tick(1'b1, '0);
    for (int b = 0; b < 60; b++) begin
      int nt, nd;
      nt = $urandom_range(1, 12);
      nd = $urandom_range(1, 70);
      for (int i = 0; i < nt; i++) tick(1'b0, rnd_tok());
      for (int i = 0; i < nd; i++) tick(1'b0, rnd_data());
      if ($urandom_range(0, 29) == 0) tick(1'b1, rnd_data());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
